// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//
// Shares the single-port data memory between the pipeline MEM stage (CPU port)
// and a secondary bus master such as the UART loader (DMA port). The CPU wins
// normally. A bounded starvation counter forces one DMA slot after STARVE_MAX
// consecutive lost contests. The CPU is stalled for that one cycle.
//
// Parameters:
//   STARVE_MAX  contested cycles the CPU may win in a row (1..15)
//   ADDR_W      address width
//   DATA_W      data width
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cpu_req/wr/addr/wdata        MEM-stage access request (store data forwarded)
//   cpu_rdata                    load data, combinational pass of mem_rdata
//   cpu_stall                    freeze the pipeline; CPU request not serviced
//   dma_req/wr/addr/wdata        DMA request, held until granted
//   dma_gnt                      DMA request serviced this cycle
//   dma_done                     one-cycle pulse, the cycle after dma_gnt
//   dma_rdata                    registered read data, valid with dma_done
//   mem_rd/wr/addr/wdata         data memory control; write lands on next edge
//   mem_rdata                    data memory combinational read data
// -----------------------------------------------------------------------------
module dm_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_wr,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_done,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic              dma_done_q, dma_done_d;
   logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

   logic contested;
   logic dma_win;
   logic cpu_win;

   // Grant decision. The >= comparison keeps the DMA slot guaranteed even if
   // the counter were ever to sit above the limit.
   always_comb begin
      contested = cpu_req & dma_req;
      dma_win   = dma_req & (~cpu_req | (starve_cnt_q >= STARVE_LIM));
      cpu_win   = cpu_req & ~dma_win;
   end

   // Starvation counter next state. The counter clears whenever DMA is served
   // or stops asking, so the CPU again gets STARVE_MAX contests before the next
   // forced DMA slot. That rules out two stall cycles in a row.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!dma_req || dma_win) begin
         starve_cnt_d = 4'd0;
      end else if (contested) begin
         if (starve_cnt_q < STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
         end
      end
   end

   // DMA completion. Read data is captured only on read grants. Write grants
   // leave the last read value in place.
   always_comb begin
      dma_done_d  = dma_win;
      dma_rdata_d = dma_rdata_q;
      if (dma_win && !dma_wr) begin
         dma_rdata_d = mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt_q <= 4'd0;
         dma_done_q   <= 1'b0;
         dma_rdata_q  <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         dma_done_q   <= dma_done_d;
         dma_rdata_q  <= dma_rdata_d;
      end
   end

   // Memory mux. When nothing is granted, the bus is driven to all-zero.
   always_comb begin
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (dma_win) begin
         mem_rd    = ~dma_wr;
         mem_wr    = dma_wr;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
      end else if (cpu_win) begin
         mem_rd    = ~cpu_wr;
         mem_wr    = cpu_wr;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end
   end

   assign dma_gnt   = dma_win;
   assign cpu_stall = cpu_req & dma_win;
   assign cpu_rdata = mem_rdata;
   assign dma_done  = dma_done_q;
   assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cpu_req, cpu_wr;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        dma_req, dma_wr;
   logic [31:0] dma_addr, dma_wdata;
   logic        dma_gnt, dma_done;
   logic [31:0] dma_rdata;
   logic        mem_rd, mem_wr;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   dm_arbiter #(.STARVE_MAX(4), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Small data memory: combinational read, write on the rising edge.
   logic [31:0] mem [0:63];
   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clk) if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;

   typedef struct {
      logic        is_dma;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        stall;
      logic        chk_rd;
      logic [31:0] rdata;
   } gnt_t;

   gnt_t        gq[$];
   logic [31:0] dq[$];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // g: 0 = no grant, 1 = CPU grant, 2 = DMA grant with done check, 3 = DMA grant
   // whose completion is cancelled by reset. erd: CPU load data (g=1) or the
   // dma_rdata expected with dma_done (g=2).
   task automatic cyc(input logic creq, input logic cwr, input logic [31:0] caddr,
                      input logic [31:0] cwd, input logic dreq, input logic dwr,
                      input logic [31:0] daddr, input logic [31:0] dwd,
                      input int g, input logic [31:0] erd);
      gnt_t e;
      cpu_req = creq; cpu_wr = cwr; cpu_addr = caddr; cpu_wdata = cwd;
      dma_req = dreq; dma_wr = dwr; dma_addr = daddr; dma_wdata = dwd;
      if (g != 0) begin
         e.is_dma = (g >= 2);
         e.wr     = e.is_dma ? dwr : cwr;
         e.addr   = e.is_dma ? daddr : caddr;
         e.wdata  = e.is_dma ? dwd : cwd;
         e.stall  = creq && e.is_dma;
         e.chk_rd = (g == 1) && !cwr;
         e.rdata  = erd;
         gq.push_back(e);
         if (g == 2) dq.push_back(erd);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
   endtask

   // Monitor: compares whenever the DUT drives the memory or completes a DMA.
   initial begin
      gnt_t e;
      forever begin
         @(negedge clk);
         if (mem_rd || mem_wr || dma_gnt) begin
            if (gq.size() == 0) begin
               chk("unexpected_grant", {31'h0, dma_gnt}, 32'hFFFF_FFFF);
            end else begin
               e = gq.pop_front();
               chk("dma_gnt", {31'h0, dma_gnt}, {31'h0, e.is_dma});
               chk("cpu_stall", {31'h0, cpu_stall}, {31'h0, e.stall});
               chk("mem_wr", {31'h0, mem_wr}, {31'h0, e.wr});
               chk("mem_rd", {31'h0, mem_rd}, {31'h0, ~e.wr});
               chk("mem_addr", mem_addr, e.addr);
               if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
               if (e.chk_rd) chk("cpu_rdata", cpu_rdata, e.rdata);
            end
         end else begin
            chk("idle_bus", {cpu_stall, mem_addr[30:0]} | mem_wdata, 32'h0);
         end
         if (dma_done) begin
            if (dq.size() == 0) chk("unexpected_done", 32'h1, 32'h0);
            else chk("dma_rdata", dma_rdata, dq.pop_front());
         end
      end
   end

   localparam logic [31:0] A10 = 32'h10, A20 = 32'h20, A30 = 32'h30;

   initial begin
      reset_n = 1'b0;
      cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_wr = 0; dma_addr = 0; dma_wdata = 0;
      @(posedge clk); #1;

      // Reset held with both requesting: CPU wins, registered outputs zero.
      cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, A20, 32'h0, 1, 32'h0);
      chk("rst_dma_done", {31'h0, dma_done}, 32'h0);
      chk("rst_dma_rdata", dma_rdata, 32'h0);
      cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, A20, 32'h0, 1, 32'h0);
      reset_n = 1'b1;
      idle();

      // CPU only: store then load back; seed memory for the DMA read.
      cyc(1'b1, 1'b1, A10, 32'hA5A5, 1'b0, 1'b0, 32'h0, 32'h0, 1, 32'h0);
      cyc(1'b1, 1'b0, A10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1, 32'hA5A5);
      cyc(1'b1, 1'b1, A20, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0, 1, 32'h0);

      // DMA only read.
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, A20, 32'h0, 2, 32'h1234);
      idle();

      // Starvation: 4 CPU wins then a DMA slot, twice (read, then write).
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 1'b0, A10, 32'h0, 1'b1, 1'b0, A10, 32'h0, 1, 32'hA5A5);
      cyc(1'b1, 1'b0, A10, 32'h0, 1'b1, 1'b0, A10, 32'h0, 2, 32'hA5A5);
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 1'b0, A10, 32'h0, 1'b1, 1'b1, A30, 32'hBEEF, 1, 32'hA5A5);
      // A DMA write leaves dma_rdata at the last read value.
      cyc(1'b1, 1'b0, A10, 32'h0, 1'b1, 1'b1, A30, 32'hBEEF, 2, 32'hA5A5);
      cyc(1'b1, 1'b0, A10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1, 32'hA5A5);
      idle();

      // Counter clear: 3 contests, one cycle without DMA, then 4 more wins.
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 1'b0, A10, 32'h0, 1'b1, 1'b0, A30, 32'h0, 1, 32'hA5A5);
      cyc(1'b1, 1'b0, A10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1, 32'hA5A5);
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 1'b0, A10, 32'h0, 1'b1, 1'b0, A30, 32'h0, 1, 32'hA5A5);
      cyc(1'b1, 1'b0, A10, 32'h0, 1'b1, 1'b0, A30, 32'h0, 2, 32'hBEEF);
      idle();

      // Mid-op reset: reset in the cycle after a DMA read grant.
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, A10, 32'h0, 3, 32'h0);
      reset_n = 1'b0;
      idle();
      chk("midrst_dma_done", {31'h0, dma_done}, 32'h0);
      chk("midrst_dma_rdata", dma_rdata, 32'h0);
      reset_n = 1'b1;
      idle();
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 1'b0, A10, 32'h0, 1'b1, 1'b0, A20, 32'h0, 1, 32'hA5A5);
      cyc(1'b1, 1'b0, A10, 32'h0, 1'b1, 1'b0, A20, 32'h0, 2, 32'h1234);
      idle();
      idle();
      idle();

      chk("grant_queue_empty", gq.size(), 32'h0);
      chk("done_queue_empty", dq.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Shares the single-port data memory between the pipeline MEM stage (CPU port) and a secondary bus master such as the UART loader (DMA port). CPU traffic normally wins. A bounded starvation counter guarantees the DMA port a slot after a fixed number of lost contests, and the pipeline is stalled for that cycle. The block sits between the EX/MEM register outputs (after lw-sw store-data forwarding) and the data memory.

## Interface

Parameters:
- STARVE_MAX, 4: contested cycles the CPU may win in a row before DMA is forced through; legal range 1..15.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  MEM stage needs memory this cycle (load or store).
- cpu_wr  in  1  1 = store, 0 = load; valid with cpu_req.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_wdata  in  DATA_W  store data, already forwarded.
- cpu_rdata  out  DATA_W  load data; combinational pass of mem_rdata.
- cpu_stall  out  1  freeze PC/IF/ID/EX/MEM this cycle; request is not serviced.
- dma_req  in  1  DMA request; held until granted.
- dma_wr  in  1  1 = write, 0 = read.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_gnt  out  1  DMA request serviced this cycle.
- dma_done  out  1  one-cycle pulse, cycle after dma_gnt.
- dma_rdata  out  DATA_W  registered read data, valid with dma_done for reads.
- mem_rd  out  1  memory read enable.
- mem_wr  out  1  memory write enable; write lands on the next rising edge.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory combinational read data.

## Operation

- A cycle is contested when cpu_req=1 and dma_req=1.
- Grant rules, evaluated combinationally each cycle:
  - Only cpu_req=1: CPU is granted.
  - Only dma_req=1: DMA is granted.
  - Contested with starve_cnt < STARVE_MAX: CPU is granted.
  - Contested with starve_cnt == STARVE_MAX: DMA is granted.
  - Neither request: no grant.
- starve_cnt is a 4-bit register, updated on each clock edge:
  - Contested cycle with CPU grant: +1, saturating at STARVE_MAX.
  - Any DMA grant: reset to 0.
  - dma_req=0: reset to 0.
- Memory mux:
  - Granted port drives mem_addr and mem_wdata; mem_wr = granted port's wr; mem_rd = !wr.
  - No grant: mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Outputs:
  - cpu_stall = cpu_req & dma_gnt.
  - dma_gnt = DMA granted.
  - cpu_rdata = mem_rdata unconditionally; only meaningful on a CPU load grant.
- On a DMA read grant, dma_rdata <= mem_rdata at the edge. On DMA write grants, dma_rdata holds its value.
- dma_done <= dma_gnt, giving a registered one-cycle pulse.
- The DMA master must drop or change its request in the cycle after dma_gnt. A held request is treated as a new transaction.
- A stalled CPU request stays stable, because the pipeline is frozen, and is serviced in the next cycle; the DMA port cannot win again until the next STARVE_MAX contests have passed.
- Reset (reset_n=0, any time, including mid-transaction):
  - starve_cnt=0, dma_done=0, dma_rdata=0, effective immediately.
  - Combinational outputs follow the inputs; no pending dma_done survives reset.

## Timing

- CPU access latency: 0 cycles. Load data is valid in the grant cycle; the store is committed at the end of the grant cycle.
- DMA access: dma_gnt in the grant cycle; dma_done and dma_rdata one cycle later.
- Worst-case DMA wait under continuous CPU traffic: STARVE_MAX+1 cycles from dma_req rising to dma_gnt.
- Worst-case CPU stall: 1 cycle per DMA grant; never 2 consecutive stall cycles.
- Reset values: dma_done=0, dma_rdata=0. cpu_stall, dma_gnt and mem_* are combinational and are 0 when no requests are present.

## Test plan

- **Reset:** hold reset_n=0 with cpu_req=1, dma_req=1 -> dma_done=0, dma_rdata=0, and CPU granted (starve_cnt=0).
- **CPU only:** cpu_req=1, cpu_wr=1, cpu_addr=0x10, cpu_wdata=0xA5A5 -> same cycle mem_wr=1, mem_addr=0x10, cpu_stall=0; a following load from 0x10 returns cpu_rdata=0xA5A5.
- **DMA only:** read at 0x20, with memory holding 0x1234 -> dma_gnt=1 that cycle; next cycle dma_done=1, dma_rdata=0x1234; starve_cnt=0.
- **Starvation, STARVE_MAX=4:** cpu_req and dma_req held high -> CPU granted for 4 cycles, 5th cycle dma_gnt=1 and cpu_stall=1, 6th cycle CPU granted and dma_done=1; the pattern repeats every 5 cycles.
- **Counter clear:** 3 contested cycles, then dma_req=0 for 1 cycle, then contested again -> the CPU wins 4 more contests before the DMA grant.
- **Mid-op reset:** assert reset_n=0 in the cycle after a DMA read grant -> dma_done forced to 0 immediately, dma_rdata=0; after release, starve_cnt restarts from 0.
